// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a fixed PAT_W-bit frame MSB first, one bit
// per clock, as a burst of rep+1 frames separated by a programmable idle gap.
module pattern_tx #(
  parameter int               PAT_W    = 8,
  parameter logic [PAT_W-1:0] PATTERN  = 8'b0101_1010,
  parameter int               GAP_W    = 4,
  parameter logic             IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       rep,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [3:0]       frames_left_reg, frames_left_next;
  logic [GAP_W-1:0] gap_len_reg, gap_len_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             done_next;
  logic             d_out_reg, d_valid_reg, busy_reg, done_reg;

  always_comb begin
    state_next       = state_reg;
    bit_idx_next     = bit_idx_reg;
    frames_left_next = frames_left_reg;
    gap_len_next     = gap_len_reg;
    gap_cnt_next     = gap_cnt_reg;
    done_next        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // abort in IDLE does nothing itself but still blocks a coincident start
        if (start && !abort) begin
          state_next       = S_SEND;
          bit_idx_next     = IDX_MAX;
          frames_left_next = rep;
          gap_len_next     = gap;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (bit_idx_reg != '0) begin
          bit_idx_next = bit_idx_reg - IDX_W'(1);
        end else if (frames_left_reg == 4'd0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          frames_left_next = frames_left_reg - 4'd1;
          if (gap_len_reg == '0) begin
            bit_idx_next = IDX_MAX;
          end else begin
            state_next   = S_GAP;
            gap_cnt_next = gap_len_reg - GAP_W'(1);
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (gap_cnt_reg == '0) begin
          state_next   = S_SEND;
          bit_idx_next = IDX_MAX;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      bit_idx_reg     <= '0;
      frames_left_reg <= '0;
      gap_len_reg     <= '0;
      gap_cnt_reg     <= '0;
      d_out_reg       <= IDLE_BIT;
      d_valid_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_idx_reg     <= bit_idx_next;
      frames_left_reg <= frames_left_next;
      gap_len_reg     <= gap_len_next;
      gap_cnt_reg     <= gap_cnt_next;
      d_out_reg       <= (state_next == S_SEND) ? PATTERN[bit_idx_next] : IDLE_BIT;
      d_valid_reg     <= (state_next == S_SEND);
      busy_reg        <= (state_next != S_IDLE);
      done_reg        <= done_next;
    end
  end

  assign d_out   = d_out_reg;
  assign d_valid = d_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: directed test-plan scenarios followed by random bursts,
// every cycle checked against a per-cycle expectation queue built from the burst rules.
module tb_pattern_tx;

  localparam int PAT_W = 8;
  localparam logic [PAT_W-1:0] PAT = 8'b0101_1010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rep = 4'd0;
  logic [3:0] gap = 4'd0;
  logic       abort = 1'b0;
  logic       d_out, d_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic d_out;
    logic d_valid;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  logic model_busy = 1'b0;
  logic [PAT_W-1:0] pat_v = PAT;
  logic [PAT_W-1:0] collected;

  pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .rep(rep), .gap(gap), .abort(abort),
    .d_out(d_out), .d_valid(d_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
    end
  endtask

  task automatic check_all(input exp_t e);
    check1("d_out", d_out, e.d_out);
    check1("d_valid", d_valid, e.d_valid);
    check1("busy", busy, e.busy);
    check1("done", done, e.done);
  endtask

  // Expected line activity of a whole burst, cycle by cycle, then the done cycle.
  task automatic push_burst(input logic [3:0] r, input logic [3:0] g);
    exp_t e;
    for (int f = 0; f <= int'(r); f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e = {pat_v[b], 1'b1, 1'b1, 1'b0};
        exp_q.push_back(e);
      end
      if (f < int'(r)) begin
        for (int k = 0; k < int'(g); k++) begin
          e = {1'b1, 1'b0, 1'b1, 1'b0};
          exp_q.push_back(e);
        end
      end
    end
    e = {1'b1, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic step(input logic s, input logic [3:0] r, input logic [3:0] g, input logic a);
    exp_t e;
    start = s; rep = r; gap = g; abort = a;
    @(posedge clk);
    if (a && model_busy) exp_q.delete();
    else if (s && !a && !model_busy) push_burst(r, g);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = {1'b1, 1'b0, 1'b0, 1'b0};
    check_all(e);
    model_busy = e.busy;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rep, gap, 1'b0);
  endtask

  initial begin
    exp_t idle_e;
    idle_e = {1'b1, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check_all(idle_e);
    @(negedge clk);
    rst = 1'b0;

    // Single frame, rep=0; also capture the bit sequence directly.
    step(1'b1, 4'd0, 4'd0, 1'b0);
    collected = {collected[PAT_W-2:0], d_out};
    for (int i = 0; i < PAT_W - 1; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b0);
      collected = {collected[PAT_W-2:0], d_out};
    end
    check1("frame_bits_5a", (collected == 8'h5A), 1'b1);
    idle_steps(3);

    // rep=2, gap=0: three back-to-back frames.
    step(1'b1, 4'd2, 4'd0, 1'b0);
    idle_steps(26);

    // rep=1, gap=3, with start re-pulse and rep/gap changes mid-burst.
    step(1'b1, 4'd1, 4'd3, 1'b0);
    idle_steps(2);
    step(1'b1, 4'd9, 4'd7, 1'b0);
    step(1'b0, 4'd5, 4'd1, 1'b0);
    idle_steps(17);

    // Start accepted in the done cycle.
    step(1'b1, 4'd0, 4'd0, 1'b0);
    idle_steps(7);
    step(1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 4'd0, 4'd2, 1'b0);
    idle_steps(10);

    // Abort in cycle 5, then a clean frame; abort+start in idle is rejected.
    step(1'b1, 4'd3, 4'd2, 1'b0);
    idle_steps(4);
    step(1'b0, 4'd3, 4'd2, 1'b1);
    idle_steps(2);
    step(1'b1, 4'd0, 4'd0, 1'b1);
    idle_steps(2);
    step(1'b1, 4'd0, 4'd0, 1'b0);
    idle_steps(10);

    // Asynchronous reset in the middle of a gap.
    step(1'b1, 4'd1, 4'd3, 1'b0);
    idle_steps(8);
    #3 rst = 1'b1;
    #1 check_all(idle_e);
    exp_q.delete();
    model_busy = 1'b0;
    #10 rst = 1'b0;
    idle_steps(4);

    // Random bursts with random disturbances.
    for (int b = 0; b < 40; b++) begin
      int len;
      step(1'b1, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0));
      len = $urandom_range(5, 120);
      for (int c = 0; c < len; c++) begin
        step(1'($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom),
             1'($urandom_range(0, 59) == 0));
      end
    end
    idle_steps(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
